mul32_seq_sched: RTL and testbench
==================================

// Module: mul32_seq_sched
// PURPOSE
//  Sequencer that computes a 2W x 2W -> 4W unsigned product using one shared W x W multiplier.
//  It issues the four partial products LL, HL, LH, HH on four consecutive cycles and
//  accumulates them with shifts. It sits in front of the techmapped $mul path.
//  Wide multiplies therefore cost one multiplier combinator cluster instead of four,
//  at the price of multi-cycle latency.
// PARAMETERS
//  HALF_W   16   half-operand width W; operands are 2W bits, result is 4W bits
// PORTS
//  clk        in   1     system clock, all state on rising edge
//  rst        in   1     asynchronous, active-high reset
//  in_valid   in   1     operand pair valid
//  in_ready   out  1     block can accept operands (high only in IDLE)
//  in_a       in   2W    multiplicand, unsigned
//  in_b       in   2W    multiplier, unsigned
//  out_valid  out  1     result valid, held until accepted
//  out_ready  in   1     consumer accepts result
//  out_y      out  4W    product in_a*in_b
//  busy       out  1     high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, operand regs=0.
//   Outputs while rst is high: in_ready=0, out_valid=0, out_y=0, busy=0.
//   in_ready=1 from the first cycle after rst deasserts.
//  States: IDLE -> P_LL -> P_HL -> P_LH -> P_HH -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready, latch a,b, clear acc, and go to P_LL.
//   Otherwise stay in IDLE.
//  P_LL: acc += a[W-1:0]*b[W-1:0]
//  P_HL: acc += (a[2W-1:W]*b[W-1:0]) << W
//  P_LH: acc += (a[W-1:0]*b[2W-1:W]) << W
//  P_HH: acc += (a[2W-1:W]*b[2W-1:W]) << 2W
//  Each phase uses exactly one multiplier op. Operand muxes are selected by state.
//   Each partial product is 2W bits, zero-extended to 4W before the shift and add.
//  acc is 4W bits. The final sum cannot exceed 4W bits, so no overflow handling is needed.
//  DONE: out_valid=1, out_y=acc. Both are stable until out_ready is sampled high.
//   Then go to IDLE.
//  Latency: accept edge at cycle 0; out_valid is high in cycle 5.
//   Throughput: at most one operation per 6 cycles.
//  No bypass: in_ready rises the cycle after the DONE handshake, never in the same cycle.
//  in_valid while busy: ignored, with no side effects. in_a/in_b are sampled only at accept.
//  out_ready while not DONE: ignored.
//  out_y outside DONE: drives 0, not stale acc, which keeps factorio wire sums clean.
//  rst asserted mid-operation: the operation is aborted immediately (asynchronously).
//   All state returns to reset values and no partial result is ever presented.
//  Zero operands follow the same path; there is no early-out, so latency is fixed.
// STRUCTURE
//  Shared package mul_seq_pkg:
//   - state enum (IDLE, P_LL, P_HL, P_LH, P_HH, DONE) as localparams, 3-bit encoding
//   - HALF_W default and the derived widths OP_W=2W, RES_W=4W
//  Sub-module mul_half_unit: combinational W x W -> 2W unsigned multiply.
//   This is the single shared resource. It is kept separate so techmap handles it
//   as a native-width $mul.
//  Top level holds the FSM, operand registers, the select muxes, and the shift-add accumulator.
// TESTING
//  1. a=0x0001FFFF, b=0x00000003, out_ready=1
//     -> out_valid exactly 5 cycles after accept, out_y=0x000000000005FFFD.
//  2. a=b=0xFFFFFFFF -> out_y=0xFFFFFFFE00000001. Checks carries across every half boundary.
//  3. a=b=0x00010000 -> out_y=0x0000000100000000. Only the HH phase contributes.
//  4. Backpressure: out_ready=0 for 10 cycles after DONE
//     -> out_valid and out_y held constant, in_ready=0 throughout.
//     On out_ready=1, in_ready=1 the next cycle.
//  5. New in_valid with different operands during P_HL -> ignored.
//     The result equals the first operation. The second pair is accepted only after return to IDLE.
//  6. rst pulse in P_LH -> out_valid never asserts, out_y=0.
//     After release, a=2, b=3 -> out_y=6 with normal 5-cycle latency.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential wide multiplier: FSM state encoding and
// default operand/result widths.
package mul_seq_pkg;

    localparam int DEF_HALF_W = 16;
    localparam int DEF_OP_W   = 2 * DEF_HALF_W;
    localparam int DEF_RES_W  = 4 * DEF_HALF_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P_LL = 3'd1,
        P_HL = 3'd2,
        P_LH = 3'd3,
        P_HH = 3'd4,
        DONE = 3'd5
    } state_e;

endpackage

// File: rtl/mul_half_unit.sv
// Combinational W x W -> 2W unsigned multiplier; the single multiplier shared
// by every phase of the sequencer.
module mul_half_unit #(
    parameter int W = 16
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/mul32_seq_sched.sv
// 2W x 2W -> 4W unsigned multiplier built from four partial products issued on
// consecutive cycles through one shared W x W multiplier.
module mul32_seq_sched
    import mul_seq_pkg::*;
#(
    parameter int HALF_W = DEF_HALF_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   in_a,
    input  logic [2*HALF_W-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*HALF_W-1:0]   out_y,
    output logic                  busy
);

    localparam int OP_W  = 2 * HALF_W;
    localparam int RES_W = 4 * HALF_W;

    state_e             state_q, state_d;
    logic [RES_W-1:0]   acc_q,   acc_d;
    logic [OP_W-1:0]    a_q,     a_d;
    logic [OP_W-1:0]    b_q,     b_d;

    logic [HALF_W-1:0]  mul_a, mul_b;
    logic [OP_W-1:0]    pp;
    logic [RES_W-1:0]   pp_ext;

    mul_half_unit #(.W(HALF_W)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    assign pp_ext = {{OP_W{1'b0}}, pp};

    // Operand halves are steered by phase so one multiplier serves all four products.
    always_comb begin
        mul_a = a_q[HALF_W-1:0];
        mul_b = b_q[HALF_W-1:0];
        case (state_q)
            P_HL: mul_a = a_q[OP_W-1:HALF_W];
            P_LH: mul_b = b_q[OP_W-1:HALF_W];
            P_HH: begin
                mul_a = a_q[OP_W-1:HALF_W];
                mul_b = b_q[OP_W-1:HALF_W];
            end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    state_d = P_LL;
                end
            end
            P_LL: begin
                acc_d   = acc_q + pp_ext;
                state_d = P_HL;
            end
            P_HL: begin
                acc_d   = acc_q + (pp_ext << HALF_W);
                state_d = P_LH;
            end
            P_LH: begin
                acc_d   = acc_q + (pp_ext << HALF_W);
                state_d = P_HH;
            end
            P_HH: begin
                acc_d   = acc_q + (pp_ext << OP_W);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // in_ready is gated by rst so nothing looks acceptable while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_y     = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_mul32_seq_sched.sv
// Self-checking bench for mul32_seq_sched: directed vectors, backpressure,
// busy-time input, mid-operation reset and randomized operands.
module tb_mul32_seq_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_y;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mul32_seq_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] y;
        int          hold;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa, wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        return wa * wb;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge after the result handshake.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold, input bit noise,
                         input bit inj, input logic [31:0] ia, input logic [31:0] ib);
        int lat;
        bit got;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        lat = 0;
        got = 1'b0;
        while (lat < 20 && !got) begin
            @(negedge clk);
            lat++;
            if (inj && lat == 2) begin
                in_valid = 1'b1;
                in_a     = ia;
                in_b     = ib;
            end
            if (out_valid) begin
                got       = 1'b1;
                out_ready = 1'b0;
            end else begin
                check({tag, " out_y_zero_busy"}, out_y, 64'd0);
                check({tag, " busy"}, 64'(busy), 64'd1);
                out_ready = noise ? 1'($urandom) : 1'b0;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd5);
        if (!got) return;
        check({tag, " out_y"}, out_y, exp);
        for (int i = 0; i < hold; i++) begin
            check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold_y"}, out_y, exp);
            check({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        check({tag, " no_bypass"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " in_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, " out_valid_after"}, 64'(out_valid), 64'd0);
        check({tag, " out_y_after"}, out_y, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0001FFFF, 32'h00000003, 64'h000000000005FFFD, 0};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 0};
        vecs[2] = '{32'h00010000, 32'h00010000, 64'h0000000100000000, 0};
        vecs[3] = '{32'hFFFF0000, 32'h0000FFFF, 64'h0000FFFE00010000, 0};
        vecs[4] = '{32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000, 0};
        vecs[5] = '{32'h80000000, 32'h00000002, 64'h0000000100000000, 2};
        vecs[6] = '{32'h00000007, 32'h00000009, 64'h000000000000003F, 10};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        #1;
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_y", out_y, 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].hold,
                  1'b0, 1'b0, 32'h0, 32'h0);

        // Second operand pair offered during P_HL stays pending until IDLE.
        do_op("busy_inj_first", 32'h00001234, 32'h00000010, 64'h0000000000012340, 1,
              1'b0, 1'b1, 32'h00000100, 32'h00000100);
        do_op("busy_inj_second", 32'h00000100, 32'h00000100, 64'h0000000000010000, 0,
              1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during P_LH aborts the operation with no result ever shown.
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h12345678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort out_y", out_y, 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort in_ready_release", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort no_result", 64'(out_valid), 64'd0);
        end
        do_op("after_abort", 32'd2, 32'd3, 64'd6, 0, 1'b0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 25; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) ra = ra & 32'h0000FFFF;
            if (i % 5 == 2) rb = rb | 32'hFFFF0000;
            do_op($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb), int'($urandom_range(0, 3)),
                  1'b1, 1'b0, 32'h0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
